// File: rtl/sti_pkg.sv
// Shared definitions for the serial-to-pixel receiver: frame length encodings,
// FSM state type, address limit and the payload extraction helper.
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecv   = 2'd1,
    StFill   = 2'd2,
    StFinish = 2'd3
  } sti_state_e;

  localparam logic [7:0] PIXEL_ADDR_LAST = 8'd255;

  // Frame bit count for a length code: 8, 16, 24 or 32.
  function automatic logic [5:0] frame_bits(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

  // The shift register holds the first serial bit at position N-1. For LSB-first
  // frames the low N bits are mirrored so that frame bit 0 is the first serial bit.
  function automatic logic [15:0] frame_payload(input logic [31:0] shift,
                                                input logic [1:0]  len,
                                                input logic        msb,
                                                input logic        low,
                                                input logic        fill);
    logic [31:0] rev;
    logic [31:0] frame;
    logic [15:0] pay;
    for (int i = 0; i < 32; i++) begin
      rev[i] = shift[31-i];
    end
    frame = msb ? shift : (rev >> (6'd32 - frame_bits(len)));
    case (len)
      LEN_8:   pay = low ? {frame[7:0], 8'h00} : {8'h00, frame[7:0]};
      LEN_16:  pay = frame[15:0];
      LEN_24:  pay = fill ? frame[23:8] : frame[15:0];
      default: pay = fill ? frame[31:16] : frame[15:0];
    endcase
    return pay;
  endfunction

endpackage

// File: rtl/sti_rx_byte_asm.sv
// Pixel byte assembler: shifts accepted serial bits in so the first bit of each
// byte lands in bit 7, counts accepted bits of the frame and flags every 8th bit.
module sti_rx_byte_asm
  import sti_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] byte_next,
  output logic [5:0] bit_cnt,
  output logic       byte_done
);

  logic [7:0] shreg_q;
  logic [5:0] cnt_q;

  assign byte_next = {shreg_q[6:0], bit_in};
  assign byte_done = shift_en && (cnt_q[2:0] == 3'd7);
  assign bit_cnt   = cnt_q;

  // Shift register and frame bit counter; cleared at the start of every frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= 8'h00;
      cnt_q   <= 6'd0;
    end else if (clear) begin
      shreg_q <= 8'h00;
      cnt_q   <= 6'd0;
    end else if (shift_en) begin
      shreg_q <= byte_next;
      cnt_q   <= cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/sti_rx.sv
// Serial frame receiver: deserialises 8..32-bit frames into a 16-bit payload and
// a stream of pixel byte writes. Optional feature macro STI_RX_ZERO_FILL_EN:
// when defined, the final frame is followed by zero writes up to address 255.
module sti_rx
  import sti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  input  logic        cfg_fill,
  input  logic        cfg_end,
  input  logic        si_data,
  input  logic        si_valid,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        pixel_wr,
  output logic [7:0]  pixel_addr,
  output logic [7:0]  pixel_dataout,
  output logic        pixel_finish,
  output logic        busy
);

  sti_state_e  state_q, state_d;
  logic [1:0]  len_q;
  logic        msb_q, low_q, fill_q, end_q;
  logic [31:0] frame_q, frame_d;
  logic [15:0] po_data_q;
  logic        po_valid_q;
  logic        pix_wr_q, pix_wr_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic [7:0]  pix_addr_q;
  logic        finish_q;
`ifdef STI_RX_ZERO_FILL_EN
  logic        ovf_q;
`endif

  logic        accept, clear, frame_last, byte_done;
  logic [7:0]  byte_next;
  logic [5:0]  bit_cnt;
  sti_state_e  end_state;

  assign accept     = (state_q == StRecv) && si_valid;
  assign clear      = (state_q == StIdle) && cfg_load;
  assign frame_last = accept && (bit_cnt == frame_bits(len_q) - 6'd1);
  assign frame_d    = {frame_q[30:0], si_data};

`ifdef STI_RX_ZERO_FILL_EN
  // An address wrap already used the whole pixel space, so no fill is needed.
  assign end_state = ovf_q ? StFinish : StFill;
`else
  assign end_state = StFinish;
`endif

  sti_rx_byte_asm u_byte_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .shift_en  (accept),
    .bit_in    (si_data),
    .byte_next (byte_next),
    .bit_cnt   (bit_cnt),
    .byte_done (byte_done)
  );

  // Next state and the pixel write request for the coming cycle.
  always_comb begin
    state_d    = state_q;
    pix_wr_d   = 1'b0;
    pix_data_d = pix_data_q;
    case (state_q)
      StIdle: if (cfg_load) state_d = StRecv;
      StRecv: if (frame_last) state_d = end_q ? end_state : StIdle;
`ifdef STI_RX_ZERO_FILL_EN
      // The write just issued at address 255 is the last one of the space.
      StFill: begin
        if (pix_wr_q && (pix_addr_q == PIXEL_ADDR_LAST)) begin
          state_d = StFinish;
        end else begin
          pix_wr_d   = 1'b1;
          pix_data_d = 8'h00;
        end
      end
`endif
      StFinish: state_d = StFinish;
      default:  state_d = StIdle;
    endcase
    if (byte_done) begin
      pix_wr_d   = 1'b1;
      pix_data_d = byte_next;
    end
  end

  // FSM, latched configuration and frame shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= LEN_8;
      msb_q   <= 1'b0;
      low_q   <= 1'b0;
      fill_q  <= 1'b0;
      end_q   <= 1'b0;
      frame_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        len_q   <= cfg_length;
        msb_q   <= cfg_msb;
        low_q   <= cfg_low;
        fill_q  <= cfg_fill;
        end_q   <= cfg_end;
        frame_q <= 32'h0;
      end else if (accept) begin
        frame_q <= frame_d;
      end
    end
  end

  // Payload strobe, issued in the cycle after the last frame bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      po_data_q  <= 16'h0;
      po_valid_q <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      po_valid_q <= frame_last;
      if (frame_last) begin
        po_data_q <= frame_payload(frame_d, len_q, msb_q, low_q, fill_q);
      end
      finish_q <= (state_q == StFinish);
    end
  end

  // Pixel write port; the address advances after each write has been presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_wr_q   <= 1'b0;
      pix_data_q <= 8'h00;
      pix_addr_q <= 8'h00;
    end else begin
      pix_wr_q   <= pix_wr_d;
      pix_data_q <= pix_data_d;
      if (pix_wr_q) pix_addr_q <= pix_addr_q + 8'd1;
    end
  end

`ifdef STI_RX_ZERO_FILL_EN
  // Sticky wrap flag for data writes; fill writes never set it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (pix_wr_q && (pix_addr_q == PIXEL_ADDR_LAST) && (state_q != StFill)) begin
      ovf_q <= 1'b1;
    end
  end
`endif

  assign po_data       = po_data_q;
  assign po_valid      = po_valid_q;
  assign pixel_wr      = pix_wr_q;
  assign pixel_addr    = pix_addr_q;
  assign pixel_dataout = pix_data_q;
  assign pixel_finish  = finish_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_sti_rx.sv
// Bench for sti_rx: table of frames plus directed end/overflow/reset sequences,
// checked by a scoreboard of expected payloads and pixel writes.
module tb_sti_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_length = 2'd0;
  logic        cfg_msb = 1'b0, cfg_low = 1'b0, cfg_fill = 1'b0, cfg_end = 1'b0;
  logic        si_data = 1'b0, si_valid = 1'b0;
  logic [15:0] po_data;
  logic        po_valid, pixel_wr, pixel_finish, busy;
  logic [7:0]  pixel_addr, pixel_dataout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int po_cyc = -1;

  logic [15:0] po_q[$];
  logic [15:0] pix_q[$];  // {addr, data}
  logic [7:0]  exp_addr;

  typedef struct {
    logic [1:0]  len;
    logic        msb;
    logic        low;
    logic        fill;
    logic [31:0] frame;
    logic [15:0] exp_po;
    bit          gap;
    bit          poke;
  } vec_t;

  vec_t vecs[8];

  sti_rx dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_load      (cfg_load),
    .cfg_length    (cfg_length),
    .cfg_msb       (cfg_msb),
    .cfg_low       (cfg_low),
    .cfg_fill      (cfg_fill),
    .cfg_end       (cfg_end),
    .si_data       (si_data),
    .si_valid      (si_valid),
    .po_data       (po_data),
    .po_valid      (po_valid),
    .pixel_wr      (pixel_wr),
    .pixel_addr    (pixel_addr),
    .pixel_dataout (pixel_dataout),
    .pixel_finish  (pixel_finish),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference payload computed from the frame value itself.
  function automatic logic [15:0] model_po(input logic [31:0] f, input logic [1:0] len,
                                           input logic low, input logic fill);
    case (len)
      2'd0:    return low ? {f[7:0], 8'h00} : {8'h00, f[7:0]};
      2'd1:    return f[15:0];
      2'd2:    return fill ? f[23:8] : f[15:0];
      default: return fill ? f[31:16] : f[15:0];
    endcase
  endfunction

  // Scoreboard: compare every payload strobe and pixel write against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (po_valid) begin
        po_cyc = cyc;
        if (po_q.size() == 0) chk("po_spurious", {31'd0, po_valid}, 32'd0);
        else chk("po_data", {16'd0, po_data}, {16'd0, po_q.pop_front()});
      end
      if (pixel_wr) begin
        if (pix_q.size() == 0) chk("pix_spurious", {31'd0, pixel_wr}, 32'd0);
        else chk("pixel", {16'd0, pixel_addr, pixel_dataout}, {16'd0, pix_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    cfg_load = 1'b0;
    si_valid = 1'b0;
    po_q.delete();
    pix_q.delete();
    exp_addr = 8'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] len, input logic msb, input logic low,
                            input logic fill, input logic fend, input logic [31:0] frame,
                            input logic [15:0] exp_po, input bit gap, input bit poke);
    int n;
    logic [31:0] s;
    logic [7:0] b;
    n = (int'(len) + 1) * 8;
    for (int i = 0; i < n; i++) s[i] = msb ? frame[n-1-i] : frame[i];
    for (int j = 0; j < n / 8; j++) begin
      for (int k = 0; k < 8; k++) b[7-k] = s[8*j+k];
      pix_q.push_back({exp_addr, b});
      exp_addr = exp_addr + 8'd1;
    end
    po_q.push_back(exp_po);
    cfg_length = len; cfg_msb = msb; cfg_low = low; cfg_fill = fill; cfg_end = fend;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap && (i % 3 == 1)) begin
        si_valid = 1'b0;
        si_data = ~s[i];
        tick();
        tick();
      end
      // A reload attempt mid-frame must not change the frame in progress.
      if (poke && i == 4) begin
        cfg_load = 1'b1; cfg_length = 2'd0; cfg_end = 1'b1; cfg_msb = ~msb;
      end else begin
        cfg_load = 1'b0;
      end
      si_valid = 1'b1;
      si_data = s[i];
      tick();
    end
    cfg_load = 1'b0;
    si_valid = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int k = 0;
    while (!pixel_finish && k < 400) begin
      tick();
      k++;
    end
    chk({name, "_finish"}, {31'd0, pixel_finish}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0012, 16'h0012, 1'b0, 1'b0};
    vecs[1] = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0048, 16'h4800, 1'b0, 1'b0};
    vecs[2] = '{2'd3, 1'b1, 1'b0, 1'b1, 32'hABCD_0000, 16'hABCD, 1'b0, 1'b0};
    vecs[3] = '{2'd2, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 16'h1234, 1'b1, 1'b0};
    vecs[4] = '{2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_BEEF, 16'hBEEF, 1'b0, 1'b1};
    vecs[5] = '{2'd3, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 16'hBEEF, 1'b1, 1'b0};
    vecs[6] = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h00C0_FFEE, 16'hC0FF, 1'b0, 1'b0};
    vecs[7] = '{2'd0, 1'b1, 1'b1, 1'b0, 32'h0000_00A5, 16'hA500, 1'b0, 1'b1};

    // Reset state.
    exp_addr = 8'd0;
    tick();
    chk("rst_po_valid", {31'd0, po_valid}, 32'd0);
    chk("rst_po_data", {16'd0, po_data}, 32'd0);
    chk("rst_pixel_wr", {31'd0, pixel_wr}, 32'd0);
    chk("rst_pixel_addr", {24'd0, pixel_addr}, 32'd0);
    chk("rst_pixel_data", {24'd0, pixel_dataout}, 32'd0);
    chk("rst_finish", {31'd0, pixel_finish}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Table of non-final frames, each from a fresh reset so pixels start at 0.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      send_frame(vecs[v].len, vecs[v].msb, vecs[v].low, vecs[v].fill, 1'b0,
                 vecs[v].frame, vecs[v].exp_po, vecs[v].gap, vecs[v].poke);
      tick();
      tick();
      chk("tbl_busy_idle", {31'd0, busy}, 32'd0);
      chk("tbl_po_drained", po_q.size(), 0);
      chk("tbl_pix_drained", pix_q.size(), 0);
    end

    // Final frame after four pixels.
    do_reset();
    send_frame(2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'hABCD_0000, 16'hABCD, 1'b0, 1'b0);
`ifdef STI_RX_ZERO_FILL_EN
    for (int a = 4; a < 256; a++) pix_q.push_back({8'(a), 8'h00});
`endif
    chk("end_busy", {31'd0, busy}, 32'd1);
    wait_finish("end");
`ifndef STI_RX_ZERO_FILL_EN
    chk("end_finish_delay", cyc - po_cyc, 1);
`endif
    chk("end_pix_drained", pix_q.size(), 0);
    cfg_load = 1'b1; cfg_end = 1'b0;
    tick();
    cfg_load = 1'b0;
    repeat (5) tick();
    chk("end_finish_held", {31'd0, pixel_finish}, 32'd1);
    chk("end_busy_held", {31'd0, busy}, 32'd1);

    // 256 pixels wrap the address; the following final frame skips any fill.
    do_reset();
    for (int f = 0; f < 64; f++) begin
      logic [31:0] fr;
      fr = $urandom;
      send_frame(2'd3, f[0], 1'b0, f[1], 1'b0, fr, model_po(fr, 2'd3, 1'b0, f[1]),
                 1'b0, 1'b0);
    end
    send_frame(2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_005A, 16'h005A, 1'b0, 1'b0);
    wait_finish("ovf");
    chk("ovf_finish_delay", cyc - po_cyc, 1);
    repeat (3) tick();
    chk("ovf_pix_drained", pix_q.size(), 0);

    // Reset after five bits of a 16-bit frame discards it.
    do_reset();
    cfg_length = 2'd1; cfg_msb = 1'b1; cfg_end = 1'b0; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      si_valid = 1'b1;
      si_data = 1'b1;
      tick();
    end
    reset = 1'b1;
    #2;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_wr", {31'd0, pixel_wr}, 32'd0);
    chk("mid_rst_addr", {24'd0, pixel_addr}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    si_valid = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_addr", {24'd0, pixel_addr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/sti_rx.md
STI_RX -- requirements
Module: sti_rx

Interface
REQ-001 clk  input  1  clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 cfg_load  input  1  one-cycle pulse; latches cfg_* fields; honoured only in IDLE.
REQ-004 cfg_length  input  2  frame length: 0=8, 1=16, 2=24, 3=32 bits.
REQ-005 cfg_msb  input  1  1: first serial bit is frame bit N-1; 0: first bit is frame bit 0.
REQ-006 cfg_low  input  1  8-bit frames only: 1 places the byte in po_data[15:8], 0 in po_data[7:0].
REQ-007 cfg_fill  input  1  24/32-bit frames only: 1 takes the payload from the top 16 frame bits, 0 from the bottom 16.
REQ-008 cfg_end  input  1  latched with cfg_load; marks the frame as the final frame.
REQ-009 si_data  input  1  serial data bit.
REQ-010 si_valid  input  1  si_data is sampled only when si_valid=1.
REQ-011 po_data  output  16  recovered 16-bit payload.
REQ-012 po_valid  output  1  one-cycle strobe; po_data is valid.
REQ-013 pixel_wr  output  1  one-cycle pixel write strobe.
REQ-014 pixel_addr  output  8  write address.
REQ-015 pixel_dataout  output  8  write data.
REQ-016 pixel_finish  output  1  high and held in FINISH.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The state machine SHALL have the states IDLE, RECV, FILL and FINISH.
REQ-019 IDLE: cfg_load SHALL latch the config and move to RECV next cycle; the bit counter SHALL clear.
REQ-020 RECV: each si_valid=1 cycle SHALL shift in one bit; si_valid=0 gaps SHALL hold the state with no timeout.
REQ-021 Pixel byte SHALL be assembled with the first received bit at pixel_dataout[7], independent of cfg_msb.
REQ-022 After every 8th accepted bit, the next cycle SHALL:
- assert pixel_wr with the assembled byte at the current pixel_addr;
- then increment pixel_addr, wrapping 255->0.
REQ-023 When bit N is accepted, the next cycle SHALL:
- assert po_valid with the payload selected per REQ-005..007 (unselected bits zero; 16-bit frames whole);
- leave RECV for FILL/FINISH if the latched end=1, else for IDLE.
REQ-024 cfg_load in RECV/FILL/FINISH SHALL be ignored.
REQ-025 FILL: one zero-data pixel_wr per cycle at addresses pixel_addr..255, then FINISH.
- If pixel_addr=0 on entry (exact wrap), go straight to FINISH with no writes.
REQ-026 FINISH SHALL be terminal until reset; pixel_wr=0, po_valid=0.
REQ-027 Combined latency from last bit to po_valid and the final pixel_wr SHALL be 1 cycle.
REQ-028 A pixel_addr wrap from 255 to 0 during RECV SHALL set the sticky internal flag ovf; ovf SHALL suppress FILL.

Reset
REQ-029 Reset SHALL force state IDLE and all of the following to 0, at any time including mid-frame and mid-FILL:
- po_data, po_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish, busy;
- counter, latched config, ovf.
REQ-030 A partially received frame SHALL be discarded on reset with no writes.

Configuration
REQ-031 Macro STI_RX_ZERO_FILL_EN, defined: final frame SHALL enter FILL per REQ-025.
REQ-032 STI_RX_ZERO_FILL_EN undefined: final frame SHALL go directly to FINISH; FILL logic absent.

Structure
REQ-033 Package sti_pkg SHALL hold:
- the cfg_length encodings (LEN_8/16/24/32);
- the state enum;
- the constant PIXEL_ADDR_LAST=8'd255.
REQ-034 Sub-module sti_rx_byte_asm SHALL hold the 8-bit shift register, the bit count and the byte-complete strobe; the top level holds the FSM, the 32-bit frame register and the address logic.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- len=0, msb=1, low=0, bits 0,0,0,1,0,0,1,0 -> po_data=0x0012; pixel addr0=0x12.
- Same bits with msb=0, low=1 -> po_data=0x4800; pixel=0x12.
- len=3, msb=1, fill=1, frame 0xABCD0000 -> po_data=0xABCD; pixels AB, CD, 00, 00 at addr 0-3.
- len=2, msb=0, fill=0, frame 0x001234 with si_valid gaps -> po_data=0x1234; first pixel=0x2C.
- End after 4 pixels with STI_RX_ZERO_FILL_EN -> 252 zero writes to addr 4-255, then pixel_finish=1; without the macro, pixel_finish=1 one cycle after po_valid.
- Reset after bit 5 of a 16-bit frame -> no pixel_wr, pixel_addr=0, state IDLE.
